// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding, defaults and constants for mul_arbiter
package mul_pkg;

  localparam int MUL_N_DEF     = 4;
  localparam int MUL_W_DEF     = 16;
  localparam int TIMEOUT_LIMIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CLR,
    ST_RESP
  } mul_state_t;

  // Width of a requester index; a single requester still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin select starting after ptr
module rr_pick
  import mul_pkg::*;
#(
  parameter int N   = MUL_N_DEF,
  parameter int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan from the slot after ptr, wrapping at N, and take the first requester
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one multiplier; MUL_ARB_TIMEOUT_EN enables the WAIT timeout
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int N = MUL_N_DEF,
  parameter int W = MUL_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic [N*W-1:0]          a_in,
  input  logic [N*W-1:0]          b_in,
  output logic [N-1:0]            gnt,
  output logic                    mul_start,
  output logic [W-1:0]            mul_a,
  output logic [W-1:0]            mul_b,
  input  logic                    mul_done,
  input  logic [2*W-1:0]          mul_p,
  output logic                    mul_clr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [idx_width(N)-1:0] rsp_id,
  output logic [2*W-1:0]          rsp_p,
  output logic                    rsp_err
);

  localparam int IDW = idx_width(N);

  mul_state_t     state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_grant;
  logic           pick_any;
  logic [N-1:0]   grant_q;
  logic           bypass;
  logic           timeout;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A zero operand makes the product trivially zero, so the multiplier is skipped
  assign bypass = (mul_a == '0) || (mul_b == '0);

`ifdef MUL_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  assign timeout = (state == ST_WAIT) && !mul_done &&
                   (wait_cnt == 8'(TIMEOUT_LIMIT - 1));

  // Count WAIT cycles and mark the response errored when the multiplier never finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (state == ST_ISSUE) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and strobes decoded from the current state
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    mul_start = 1'b0;
    mul_clr   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        gnt       = grant_q;
        mul_start = !bypass;
        state_nxt = bypass ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done || timeout) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        mul_clr   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner in IDLE, capture the product in WAIT, move the pointer on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= IDW'(N - 1);
      grant_q <= '0;
      rsp_id  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      rsp_p   <= '0;
    end else begin
      if (state == ST_IDLE && pick_any) begin
        grant_q <= pick_grant;
        rsp_id  <= pick_idx;
        mul_a   <= a_in[int'(pick_idx)*W +: W];
        mul_b   <= b_in[int'(pick_idx)*W +: W];
      end
      if (state == ST_ISSUE) begin
        rsp_p <= '0;
      end
      if (state == ST_WAIT && mul_done) begin
        rsp_p <= mul_p;
      end
      if (state == ST_RESP && rsp_ready) begin
        ptr <= rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - self-checking bench for mul_arbiter with a transaction timeline model
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_done;
  logic [2*W-1:0]   mul_p;
  logic             mul_clr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_p;
  logic             rsp_err;

  mul_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .mul_clr   (mul_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier environment: done rises lat cycles after start, cleared by mul_clr; lat=0 never finishes
  int lat = 3;
  int env_cnt = 0;
  initial begin
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(posedge clk);
      if (!rst_n || mul_clr) begin
        mul_done <= 1'b0;
        env_cnt  <= 0;
      end else if (mul_start) begin
        mul_p   <= (2*W)'(mul_a) * (2*W)'(mul_b);
        env_cnt <= lat;
      end else if (env_cnt > 1) begin
        env_cnt <= env_cnt - 1;
      end else if (env_cnt == 1) begin
        mul_done <= 1'b1;
        env_cnt  <= 0;
      end
    end
  end

  // Timeline model: one transaction at a time, each described by the cycles its events fall on
  int           cyc = 0;
  bit           m_busy;
  int           m_ptr, m_w;
  logic [W-1:0] m_a, m_b;
  logic [2*W-1:0] m_p;
  bit           m_err;
  int           t_gnt, t_start, t_wait, t_clr, t_rsp;

  task automatic model_reset();
    m_busy = 0; m_ptr = N - 1; m_w = 0; m_err = 0; m_p = '0;
    t_gnt = -1; t_start = -1; t_wait = -1; t_clr = -1; t_rsp = -1;
  endtask

  initial begin
    int c;
    model_reset();
    forever begin
      @(posedge clk);
      c = cyc;
      if (!rst_n) begin
        model_reset();
      end else if (!m_busy && req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!m_busy && req[j]) begin
            m_busy = 1;
            m_w    = j;
          end
        end
        m_a   = a_in[m_w*W +: W];
        m_b   = b_in[m_w*W +: W];
        m_p   = (2*W)'(m_a) * (2*W)'(m_b);
        m_err = 0;
        t_gnt = c + 1;
        t_clr = -1;
        if (m_a == 0 || m_b == 0) begin
          t_start = -1; t_wait = -1; t_rsp = c + 2;
        end else begin
          t_start = c + 1; t_wait = c + 2; t_rsp = -1;
        end
      end else if (m_busy) begin
        if (t_rsp < 0 && t_wait >= 0 && c >= t_wait) begin
          if (mul_done) begin
            t_clr = c + 1; t_rsp = c + 2;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (c - t_wait + 1 >= 255) begin
            t_clr = c + 1; t_rsp = c + 2; m_err = 1; m_p = '0;
          end
`endif
        end else if (t_rsp >= 0 && c >= t_rsp && rsp_ready) begin
          m_busy = 0;
          m_ptr  = m_w;
        end
      end
      cyc = c + 1;
    end
  end

  // Compare process: every cycle, away from the active edge
  int gnt_cnt = 0, start_cnt = 0, clr_cnt = 0;
  int gq[$];
  initial begin
    forever begin
      logic [N-1:0] e_gnt;
      bit e_rv;
      @(negedge clk);
      e_gnt = (m_busy && cyc == t_gnt) ? N'(1 << m_w) : '0;
      e_rv  = m_busy && t_rsp >= 0 && cyc >= t_rsp;
      check("gnt", gnt, e_gnt);
      check("mul_start", mul_start, m_busy && cyc == t_start);
      check("mul_clr", mul_clr, m_busy && cyc == t_clr);
      check("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        check("rsp_id", rsp_id, m_w);
        check("rsp_p", rsp_p, m_p);
        check("rsp_err", rsp_err, m_err);
      end
      if (m_busy && cyc == t_start) begin
        check("mul_a", mul_a, m_a);
        check("mul_b", mul_b, m_b);
      end
      if (gnt != '0) begin
        gnt_cnt++;
        for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
      end
      if (mul_start) start_cnt++;
      if (mul_clr) clr_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int i, input int limit);
    int n = 0;
    while (!gnt[i] && n < limit) begin tick(); n++; end
    check($sformatf("wait_gnt%0d", i), gnt[i], 1'b1);
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin tick(); n++; end
    check("wait_rsp", rsp_valid, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_busy || rsp_valid) && n < limit) begin tick(); n++; end
    check("wait_idle", m_busy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt"}, gnt, 4'b0000);
    check({tag, "_start"}, mul_start, 1'b0);
    check({tag, "_clr"}, mul_clr, 1'b0);
    check({tag, "_rv"}, rsp_valid, 1'b0);
    check({tag, "_err"}, rsp_err, 1'b0);
    check({tag, "_id"}, rsp_id, 2'd0);
    check({tag, "_p"}, rsp_p, 32'd0);
    check({tag, "_a"}, mul_a, 16'd0);
    check({tag, "_b"}, mul_b, 16'd0);
  endtask

  task automatic set_slot(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    reset_checks("rst");
    rst_n = 1'b1;
    tick();

    // All four requesting continuously: strict rotation from requester 0
    for (int i = 0; i < N; i++) set_slot(i, i + 2, 3);
    lat = 3;
    req = 4'hF;
    n = 0;
    while (gq.size() < 5 && n < 300) begin tick(); n++; end
    req = '0;
    wait_idle(100);
    check("order_len", gq.size() >= 5, 1'b1);
    if (gq.size() >= 5) begin
      check("order0", gq[0], 0);
      check("order1", gq[1], 1);
      check("order2", gq[2], 2);
      check("order3", gq[3], 3);
      check("order4", gq[4], 0);
    end

    // Single requester 2, 7*6 with a slow multiplier
    gnt_cnt = 0; start_cnt = 0; clr_cnt = 0;
    lat = 10;
    set_slot(2, 7, 6);
    req = 4'b0100;
    wait_gnt(2, 10);
    check("single_gnt", gnt, 4'b0100);
    req = '0;
    wait_rsp(50);
    check("single_id", rsp_id, 2'd2);
    check("single_p", rsp_p, 32'd42);
    wait_idle(20);
    check("single_gnt_pulses", gnt_cnt, 1);
    check("single_starts", start_cnt, 1);
    check("single_clrs", clr_cnt, 1);

    // Zero operand: bypass the multiplier, response two cycles after the request
    gnt_cnt = 0; start_cnt = 0; clr_cnt = 0;
    lat = 3;
    set_slot(1, 0, 9);
    req = 4'b0010;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick(); n++;
      if (gnt[1]) req[1] = 1'b0;
    end
    check("bypass_latency", n, 2);
    check("bypass_p", rsp_p, 32'd0);
    wait_idle(20);
    check("bypass_starts", start_cnt, 0);
    check("bypass_clrs", clr_cnt, 0);
    check("bypass_gnts", gnt_cnt, 1);

    // Back-pressure: response held stable, competing request waits for the handshake
    rsp_ready = 1'b0;
    set_slot(3, 5, 5);
    set_slot(0, 2, 2);
    req = 4'b1000;
    wait_gnt(3, 10);
    req = 4'b0001;
    wait_rsp(30);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_rv", rsp_valid, 1'b1);
      check("stall_id", rsp_id, 2'd3);
      check("stall_p", rsp_p, 32'd25);
      check("stall_gnt", gnt, 4'b0000);
    end
    rsp_ready = 1'b1;
    wait_gnt(0, 10);
    check("after_stall_gnt", gnt, 4'b0001);
    req = '0;
    wait_idle(30);

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier never finishes: timeout clears it and returns an error
    clr_cnt = 0;
    lat = 0;
    set_slot(2, 3, 3);
    req = 4'b0100;
    wait_gnt(2, 10);
    req = '0;
    wait_rsp(400);
    check("timeout_err", rsp_err, 1'b1);
    check("timeout_p", rsp_p, 32'd0);
    check("timeout_clrs", clr_cnt, 1);
    wait_idle(20);
    lat = 3;
`endif

    // Reset while waiting on the multiplier: outputs drop at once, requester 0 wins next
    lat = 50;
    set_slot(1, 4, 4);
    req = 4'b0010;
    wait_gnt(1, 10);
    req = '0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    tick();
    tick();
    lat = 3;
    for (int i = 0; i < N; i++) set_slot(i, i + 1, 2);
    req = 4'hF;
    rst_n = 1'b1;
    wait_gnt(0, 10);
    check("post_rst_gnt", gnt, 4'b0001);
    req = '0;
    wait_idle(30);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
